// File: rtl/adpcm_mul_pkg.sv
// Shared width and constant helpers for the ADPCM pipelined multiplier.
// All post-processing arithmetic is carried out in MAX_W-bit signed values.
package adpcm_mul_pkg;

    localparam int MAX_W = 64;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_max(input int w, input int is_signed);
        if (is_signed != 0)
            return (64'sd1 <<< (w - 1)) - 64'sd1;
        return (64'sd1 <<< w) - 64'sd1;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_min(input int w, input int is_signed);
        if (is_signed != 0)
            return -(64'sd1 <<< (w - 1));
        return 64'sd0;
    endfunction

    // Round half toward +infinity: add half an output LSB before the shift.
    function automatic logic signed [MAX_W-1:0] round_const(input int shift, input int rnd);
        if (rnd != 0 && shift > 0)
            return 64'sd1 <<< (shift - 1);
        return 64'sd0;
    endfunction

endpackage

// File: rtl/adpcm_mul_postproc.sv
// Combinational round / arithmetic shift / saturate (or truncate) of the exact product.
module adpcm_mul_postproc
    import adpcm_mul_pkg::*;
#(
    parameter int PW         = 30,
    parameter int DW         = 29,
    parameter int OUT_SIGNED = 0,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 0
) (
    input  logic signed [PW-1:0] prod_i,
    output logic [DW-1:0]        dout_o,
    output logic                 sat_o
);

    localparam logic signed [MAX_W-1:0] RND = round_const(SHIFT, ROUND);
    localparam logic signed [MAX_W-1:0] HI  = sat_max(DW, OUT_SIGNED);
    localparam logic signed [MAX_W-1:0] LO  = sat_min(DW, OUT_SIGNED);

    logic signed [MAX_W-1:0] ext;
    logic signed [MAX_W-1:0] shifted;

    // Headroom above PW keeps the rounding add from wrapping.
    assign ext     = {{(MAX_W-PW){prod_i[PW-1]}}, prod_i};
    assign shifted = (ext + RND) >>> SHIFT;

    always_comb begin
        dout_o = shifted[DW-1:0];
        sat_o  = 1'b0;
        if (SAT != 0) begin
            if (shifted > HI) begin
                dout_o = HI[DW-1:0];
                sat_o  = 1'b1;
            end else if (shifted < LO) begin
                dout_o = LO[DW-1:0];
                sat_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adpcm_main_mul_pipe.sv
// Pipelined fixed-point multiplier with per-operand signedness and optional round/shift/saturate.
// A valid bit travels alongside the data; ce stalls every register, reset clears valid and outputs.
module adpcm_main_mul_pipe
    import adpcm_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 15,
    parameter int din1_WIDTH  = 14,
    parameter int dout_WIDTH  = 29,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int OUT_SIGNED  = 0,
    parameter int SHIFT       = 0,
    parameter int ROUND       = 0,
    parameter int SAT         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  vld_in,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  vld_out,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat_flag
);

    localparam int PW = prod_width(din0_WIDTH, din1_WIDTH) + 1;

    if (NUM_STAGE < 1 || NUM_STAGE > 6) begin : g_bad_stage
        $fatal(1, "adpcm_main_mul_pipe ID=%0d: NUM_STAGE=%0d outside 1..6", ID, NUM_STAGE);
    end
    if (SHIFT < 0 || SHIFT > PW - 2) begin : g_bad_shift
        $fatal(1, "adpcm_main_mul_pipe ID=%0d: SHIFT=%0d out of range", ID, SHIFT);
    end
    if (PW > MAX_W - 2 || dout_WIDTH > MAX_W - 2) begin : g_bad_width
        $fatal(1, "adpcm_main_mul_pipe ID=%0d: operand/result widths too large", ID);
    end

    logic signed [PW-1:0] a_ext, b_ext;
    logic                 sx0, sx1;

    assign sx0   = (DIN0_SIGNED != 0) && din0[din0_WIDTH-1];
    assign sx1   = (DIN1_SIGNED != 0) && din1[din1_WIDTH-1];
    assign a_ext = {{(PW-din0_WIDTH){sx0}}, din0};
    assign b_ext = {{(PW-din1_WIDTH){sx1}}, din1};

    logic signed [PW-1:0] prod_last;

    if (NUM_STAGE == 1) begin : g_comb
        assign prod_last = a_ext * b_ext;
    end else begin : g_pipe
        logic signed [PW-1:0] opa_p1_q, opb_p1_q;
        logic signed [PW-1:0] mul_p1;

        // Stage 1: extended operands.
        always_ff @(posedge clk) begin
            if (ce) begin
                opa_p1_q <= a_ext;
                opb_p1_q <= b_ext;
            end
        end

        assign mul_p1 = opa_p1_q * opb_p1_q;

        if (NUM_STAGE == 2) begin : g_no_retime
            assign prod_last = mul_p1;
        end else begin : g_retime
            logic signed [PW-1:0] prod_q [NUM_STAGE-2];

            // Stages 2..NUM_STAGE-1: product retiming.
            always_ff @(posedge clk) begin
                if (ce) begin
                    prod_q[0] <= mul_p1;
                    for (int i = 1; i < NUM_STAGE - 2; i++)
                        prod_q[i] <= prod_q[i-1];
                end
            end

            assign prod_last = prod_q[NUM_STAGE-3];
        end
    end

    logic [dout_WIDTH-1:0] dout_d, dout_q;
    logic                  sat_d, sat_q;
    logic [NUM_STAGE-1:0]  vld_q;

    adpcm_mul_postproc #(
        .PW         (PW),
        .DW         (dout_WIDTH),
        .OUT_SIGNED (OUT_SIGNED),
        .SHIFT      (SHIFT),
        .ROUND      (ROUND),
        .SAT        (SAT)
    ) u_postproc (
        .prod_i (prod_last),
        .dout_o (dout_d),
        .sat_o  (sat_d)
    );

    // Final stage: post-processed result and valid chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else if (ce) begin
            vld_q[0] <= vld_in;
            for (int i = 1; i < NUM_STAGE; i++)
                vld_q[i] <= vld_q[i-1];
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

    assign vld_out  = vld_q[NUM_STAGE-1];
    assign dout     = dout_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_adpcm_main_mul_pipe.sv
// Scoreboard bench: drivers push expected results tagged with their due enabled-edge count,
// a negedge monitor pops and compares whenever an instance presents a fresh vld_out.
module tb_adpcm_main_mul_pipe;

    localparam int NI = 12;
    localparam int W0 = 15;
    localparam int W1 = 14;
    // 0: defaults, 1: all signed, 2/3: signed Q-shift with/without rounding,
    // 4..7: NUM_STAGE=1 signedness sweep, 8..11: NUM_STAGE=6 sweep with round/shift/sat.
    localparam int NS [NI] = '{3, 3, 3, 3, 1, 1, 1, 1, 6, 6, 6, 6};
    localparam int DW [NI] = '{29, 29, 12, 12, 29, 29, 29, 29, 20, 20, 20, 20};
    localparam int S0 [NI] = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    localparam int S1 [NI] = '{0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    localparam int OS [NI] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    localparam int SH [NI] = '{0, 0, 15, 15, 0, 0, 0, 0, 5, 5, 5, 5};
    localparam int RD [NI] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    localparam int ST [NI] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]           rst_a, ce_a, vin_a;
    logic [NI-1:0][W0-1:0]   d0_a;
    logic [NI-1:0][W1-1:0]   d1_a;
    logic [NI-1:0]           vo_a, so_a;
    logic [NI-1:0][63:0]     do_a;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DW[g]-1:0] dout_w;

        adpcm_main_mul_pipe #(
            .ID          (g),
            .NUM_STAGE   (NS[g]),
            .din0_WIDTH  (W0),
            .din1_WIDTH  (W1),
            .dout_WIDTH  (DW[g]),
            .DIN0_SIGNED (S0[g]),
            .DIN1_SIGNED (S1[g]),
            .OUT_SIGNED  (OS[g]),
            .SHIFT       (SH[g]),
            .ROUND       (RD[g]),
            .SAT         (ST[g])
        ) u_dut (
            .clk      (clk),
            .reset    (rst_a[g]),
            .ce       (ce_a[g]),
            .vld_in   (vin_a[g]),
            .din0     (d0_a[g]),
            .din1     (d1_a[g]),
            .vld_out  (vo_a[g]),
            .dout     (dout_w),
            .sat_flag (so_a[g])
        );

        assign do_a[g] = 64'(dout_w);
    end

    typedef struct {
        logic [63:0] d;
        logic        s;
        int          due;
    } exp_t;

    exp_t        q [NI][$];
    int          en_cnt   [NI] = '{default: 0};
    bit          last_en  [NI] = '{default: 0};
    bit          last_rst [NI] = '{default: 1};
    bit          held_v   [NI] = '{default: 0};
    logic [63:0] held_d   [NI];
    logic        held_s   [NI];
    int          n_chk = 0;
    int          n_err = 0;

    function automatic logic [63:0] dmask(input int i);
        return (64'd1 << DW[i]) - 64'd1;
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d: got %0d (0x%0h) required %0d (0x%0h)", nm, i, act, act, exp, exp);
        end
    endtask

    // Reference: exact product, optional round, arithmetic shift, clamp or wrap.
    function automatic logic [64:0] model(input int i, input logic [31:0] a, input logic [31:0] b);
        longint va, vb, r, hi, lo;
        logic   s;
        va = longint'(a);
        vb = longint'(b);
        if (S0[i] != 0 && a[W0-1]) va -= longint'(1) << W0;
        if (S1[i] != 0 && b[W1-1]) vb -= longint'(1) << W1;
        r = va * vb;
        if (RD[i] != 0 && SH[i] > 0) r += longint'(1) << (SH[i] - 1);
        r = r >>> SH[i];
        s = 1'b0;
        if (ST[i] != 0) begin
            hi = (OS[i] != 0) ? (longint'(1) << (DW[i] - 1)) - 1 : (longint'(1) << DW[i]) - 1;
            lo = (OS[i] != 0) ? -(longint'(1) << (DW[i] - 1)) : longint'(0);
            if (r > hi) begin
                r = hi;
                s = 1'b1;
            end else if (r < lo) begin
                r = lo;
                s = 1'b1;
            end
        end
        return {s, 64'(r) & dmask(i)};
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input longint e, input logic s);
        exp_t x;
        d0_a[i]  = a[W0-1:0];
        d1_a[i]  = b[W1-1:0];
        vin_a[i] = 1'b1;
        x.d   = 64'(e) & dmask(i);
        x.s   = s;
        x.due = en_cnt[i] + NS[i];
        q[i].push_back(x);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            last_rst[i] = rst_a[i];
            last_en[i]  = ce_a[i] && !rst_a[i];
            if (last_en[i]) en_cnt[i]++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (last_rst[i]) begin
                held_v[i] = 1'b0;
            end else if (last_en[i]) begin
                held_v[i] = 1'b0;
                if (vo_a[i]) begin
                    if (q[i].size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_vld_out inst=%0d: got 1 required 0 (dout=%0d)", i, do_a[i]);
                    end else begin
                        e = q[i].pop_front();
                        chk("dout", i, do_a[i], e.d);
                        chk("sat_flag", i, 64'(so_a[i]), 64'(e.s));
                        chk("latency", i, 64'(en_cnt[i]), 64'(e.due));
                        held_v[i] = 1'b1;
                        held_d[i] = e.d;
                        held_s[i] = e.s;
                    end
                end else if (q[i].size() != 0 && q[i][0].due <= en_cnt[i]) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL missing_result inst=%0d: got vld_out=0 required 1 (dout %0d)", i, q[i][0].d);
                    void'(q[i].pop_front());
                end
            end else begin
                chk("stall_vld_out", i, 64'(vo_a[i]), 64'(held_v[i]));
                if (held_v[i]) begin
                    chk("stall_dout", i, do_a[i], held_d[i]);
                    chk("stall_sat_flag", i, 64'(so_a[i]), 64'(held_s[i]));
                end
            end
        end
    end

    logic [31:0] ra, rb;
    logic [64:0] r;
    logic [31:0] corner_a [4] = '{32'h7fff, 32'h4000, 32'h7fff, 32'h0000};
    logic [31:0] corner_b [4] = '{32'h3fff, 32'h3fff, 32'h2000, 32'h3fff};

    initial begin
        rst_a = '1;
        ce_a  = '1;
        vin_a = '0;
        d0_a  = '0;
        d1_a  = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_vld_out", i, 64'(vo_a[i]), 64'd0);
            chk("reset_dout", i, do_a[i], 64'd0);
            chk("reset_sat_flag", i, 64'(so_a[i]), 64'd0);
        end
        rst_a = '0;

        // Directed products and Q-format round/shift/saturate cases.
        issue(0, 32767, 16383, 536821761, 1'b0);
        issue(1, 32'h4000, 8191, -134201344, 1'b0);
        issue(2, 12288, 4, 2, 1'b0);
        issue(3, 12288, 4, 1, 1'b0);
        @(negedge clk);
        vin_a = '0;
        issue(2, 32'h5000, 4, -1, 1'b0);
        issue(3, 32'h5000, 4, -2, 1'b0);
        @(negedge clk);
        vin_a = '0;
        issue(2, 32'h4000, 32'h2000, 2047, 1'b1);
        issue(3, 32'h4000, 32'h2000, 2047, 1'b1);
        @(negedge clk);
        vin_a = '0;
        repeat (5) @(negedge clk);

        // Clock-enable stalls: one with the pipe filling, one with a result on the output.
        issue(0, 3, 5, 15, 1'b0);
        @(negedge clk);
        issue(0, 100, 200, 20000, 1'b0);
        @(negedge clk);
        vin_a[0] = 1'b0;
        ce_a[0]  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ce_a[0] = 1'b1;
        issue(0, 1000, 1000, 1000000, 1'b0);
        @(negedge clk);
        vin_a[0] = 1'b0;
        @(negedge clk);
        ce_a[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ce_a[0] = 1'b1;
        repeat (6) @(negedge clk);

        // Reset with two items in flight; they must never appear.
        issue(0, 7, 9, 63, 1'b0);
        @(negedge clk);
        issue(0, 11, 13, 143, 1'b0);
        @(negedge clk);
        vin_a[0] = 1'b0;
        rst_a[0] = 1'b1;
        @(negedge clk);
        rst_a[0] = 1'b0;
        chk("midreset_vld_out", 0, 64'(vo_a[0]), 64'd0);
        chk("midreset_dout", 0, do_a[0], 64'd0);
        chk("midreset_sat_flag", 0, 64'(so_a[0]), 64'd0);
        q[0].delete();
        issue(0, 21, 2, 42, 1'b0);
        @(negedge clk);
        vin_a[0] = 1'b0;
        repeat (6) @(negedge clk);

        // NUM_STAGE=1 and 6, every signedness combination: corners then random vectors.
        for (int c = 0; c < 1000; c++) begin
            for (int i = 4; i < NI; i++) begin
                if (c < 4) begin
                    ra = corner_a[c];
                    rb = corner_b[c];
                end else begin
                    ra = $urandom & 32'h7fff;
                    rb = $urandom & 32'h3fff;
                end
                if (c < 4 || $urandom_range(3) != 0) begin
                    r = model(i, ra, rb);
                    issue(i, ra, rb, longint'(r[63:0]), r[64]);
                end else begin
                    vin_a[i] = 1'b0;
                    d0_a[i]  = ra[W0-1:0];
                    d1_a[i]  = rb[W1-1:0];
                end
            end
            @(negedge clk);
        end
        vin_a = '0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < NI; i++)
            chk("drained", i, 64'(q[i].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adpcm_main_mul_pipe.md
Name: adpcm_main_mul_pipe

Overview:
Parametrised, pipelined fixed-point multiplier for the ADPCM datapath. It supersedes the fixed-width combinational unsigned multipliers. Each operand is independently signed or unsigned, and the output stage can optionally round, shift and saturate. Throughput is one product per clock enable; a valid bit travels with the data. It instantiates inside adpcm_main wherever the quantiser and predictor need a Q-format product.

Parameters:
ID, 1, instance tag; no functional effect.
NUM_STAGE, 3, latency in enabled cycles; legal range 1..6.
din0_WIDTH, 15, operand A width.
din1_WIDTH, 14, operand B width.
dout_WIDTH, 29, result width.
DIN0_SIGNED, 0, 1 = din0 is two's complement.
DIN1_SIGNED, 0, 1 = din1 is two's complement.
OUT_SIGNED, 0, selects the signed or unsigned saturation range.
SHIFT, 0, arithmetic right shift applied to the product; range 0..din0_WIDTH+din1_WIDTH-1.
ROUND, 0, 1 = add 2^(SHIFT-1) before the shift; ignored when SHIFT=0.
SAT, 0, 1 = clamp to the dout range; 0 = truncate to the low dout_WIDTH bits.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ce  in  1  pipeline advance enable
vld_in  in  1  din0/din1 qualify this cycle
din0  in  din0_WIDTH  operand A
din1  in  din1_WIDTH  operand B
vld_out  out  1  dout/sat_flag are a new result
dout  out  dout_WIDTH  result
sat_flag  out  1  saturation occurred on this result (always 0 when SAT=0)

Behaviour:
- Single clock domain. reset is synchronous and active-high and overrides ce.
- Reset values: all valid bits 0, dout 0, sat_flag 0. In-flight data is discarded.
- Pipeline advance:
  - The pipeline advances only on cycles where ce=1.
  - With ce=0, every stage register, including the outputs, holds its value.
- Latency: a (vld_in, din0, din1) sampled on an enabled edge appears on dout/vld_out after exactly NUM_STAGE enabled edges.
- Throughput: back-to-back inputs are accepted every enabled cycle; there is no backpressure.
- Data registers may load regardless of vld_in. vld_out is the sole qualifier of the output.
- Stage mapping:
  - NUM_STAGE=1: multiply, round/shift and saturate all combinational, then the output register.
  - NUM_STAGE>=2: stage 1 registers the extended operands. The last stage registers the post-processed result. Stages in between are product retiming registers.
- Arithmetic:
  - P = din0_WIDTH + din1_WIDTH.
  - Each operand is sign-extended when its SIGNED parameter is 1, otherwise zero-extended, to P+1 bits.
  - Form the exact signed product in P+1 bits.
  - If ROUND=1 and SHIFT>0, add 2^(SHIFT-1) (round half toward +infinity).
  - Arithmetic right shift by SHIFT.
  - SAT=1: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1] when OUT_SIGNED=1, else [0, 2^dout_WIDTH-1]. sat_flag=1 when the clamp changed the value.
  - SAT=0: keep the low dout_WIDTH bits.
- sat_flag is registered alongside dout and is meaningful only when vld_out=1.
- Elaboration check: NUM_STAGE outside 1..6 or SHIFT out of range is a fatal error.

Decomposition:
- Package adpcm_mul_pkg holds:
  - localparam helpers: product width, saturation max/min as functions of width and signedness.
  - The rounding-constant function.
- One natural sub-module: adpcm_mul_postproc, a combinational round/shift/saturate block instantiated before the final register.
- The valid/delay chain stays inline.

Test Plan:
1. Default params: din0=32767, din1=16383, vld_in=1, ce=1 -> 3 cycles later dout=536821761, sat_flag=0, vld_out high for exactly one cycle.
2. DIN0_SIGNED=DIN1_SIGNED=OUT_SIGNED=1: din0=15'h4000 (-16384), din1=8191 -> dout=-134201344 after NUM_STAGE cycles.
3. Signed, SHIFT=15, ROUND=1, SAT=1, dout_WIDTH=12:
   - 12288*4 -> 2 (ROUND=0 gives 1).
   - -12288*4 -> -1.
   - -16384*-8192 -> 2047 with sat_flag=1.
4. ce stall: issue 3 back-to-back vectors, drop ce for 2 cycles after the second -> outputs and vld_out frozen during the stall. All three results emerge in order after 3 enabled edges each, none lost or duplicated.
5. Reset mid-flight: assert reset for 1 cycle with 2 items in the pipe -> next cycle vld_out=0, dout=0, sat_flag=0. Neither item ever appears. A vector issued the cycle after reset deasserts emerges NUM_STAGE cycles later.
6. Sweep NUM_STAGE=1 and 6 with 1000 random vectors per signedness combination -> every result matches the reference model at the exact latency.
